// File: rtl/jt10_adpcma_pkg.sv
// Shared constants and helpers for the ADPCM-A pan/level mixer.
// Holds the attenuation mantissa table and the 12-bit clamp.
package jt10_adpcma_pkg;

  localparam int CH_NUM_DEF = 6;
  localparam int PCM_W      = 12;
  localparam int ACC_W      = 15;
  localparam int OUT_W      = 16;
  localparam int PROD_W     = 20;

  localparam logic [7:0] MANT [8] = '{
    8'd128, 8'd117, 8'd108, 8'd99,
    8'd91,  8'd83,  8'd76,  8'd70
  };

  localparam logic signed [ACC_W-1:0] SMAX = 15'sd2047;
  localparam logic signed [ACC_W-1:0] SMIN = -15'sd2048;

  function automatic logic [PCM_W-1:0] sat12(
    input logic signed [ACC_W-1:0] v
  );
    logic [PCM_W-1:0] r;
    if (v > SMAX)
      r = 12'h7ff;
    else if (v < SMIN)
      r = 12'h800;
    else
      r = v[PCM_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/jt10_adpcma_atten.sv
// Stage A: mantissa lookup, 12x8 multiply and shift select.
// Registers product, shift, pan, channel and valid on clk_en.
module jt10_adpcma_atten
  import jt10_adpcma_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clk_en_i,
  input  logic                     vld_i,
  input  logic signed [PCM_W-1:0]  pcm_i,
  input  logic [2:0]               ch_i,
  input  logic [5:0]               atten_i,
  input  logic [1:0]               pan_i,
  output logic                     vld_o,
  output logic signed [PROD_W-1:0] prod_o,
  output logic [2:0]               shift_o,
  output logic [1:0]               pan_o,
  output logic [2:0]               ch_o
);

  logic [7:0]               mant;
  logic signed [20:0]       prod_full;
  logic signed [PROD_W-1:0] prod_d;

  logic                     vld_q;
  logic signed [PROD_W-1:0] prod_q;
  logic [2:0]               shift_q;
  logic [1:0]               pan_q;
  logic [2:0]               ch_q;

  assign mant = MANT[atten_i[2:0]];

  // |pcm * mant| <= 2^18, so the 21-bit product fits 20 bits signed
  assign prod_full = $signed({{9{pcm_i[PCM_W-1]}}, pcm_i})
                   * $signed({13'd0, mant});
  assign prod_d = prod_full[PROD_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= 1'b0;
      prod_q  <= '0;
      shift_q <= '0;
      pan_q   <= '0;
      ch_q    <= '0;
    end else if (clk_en_i) begin
      vld_q   <= vld_i;
      prod_q  <= prod_d;
      shift_q <= atten_i[5:3];
      pan_q   <= pan_i;
      ch_q    <= ch_i;
    end
  end

  assign vld_o   = vld_q;
  assign prod_o  = prod_q;
  assign shift_o = shift_q;
  assign pan_o   = pan_q;
  assign ch_o    = ch_q;

endmodule

// File: rtl/jt10_adpcma_mix.sv
// Six-channel ADPCM-A pan/level mixer with per-frame held outputs.
// JT10_ADPCMA_SAT_EN clamps the frame sum instead of wrapping it.
module jt10_adpcma_mix
  import jt10_adpcma_pkg::*;
#(
  parameter int CH_NUM = CH_NUM_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clk_en,
  input  logic                    pcm_vld,
  input  logic signed [PCM_W-1:0] pcm_in,
  input  logic [2:0]              pcm_ch,
  input  logic [5:0]              atten,
  input  logic [1:0]              pan,
  output logic signed [OUT_W-1:0] adpcmA_l,
  output logic signed [OUT_W-1:0] adpcmA_r,
  output logic                    out_stb,
  output logic                    seq_err
);

  localparam logic [2:0] LAST = 3'(CH_NUM - 1);

  logic       ch_ok;
  logic       accept;
  logic [2:0] exp_ch_q, exp_ch_d;
  logic       seq_err_q, seq_err_d;

  assign ch_ok  = (pcm_ch <= LAST);
  assign accept = clk_en & pcm_vld & ch_ok;

  always_comb begin
    exp_ch_d  = exp_ch_q;
    seq_err_d = seq_err_q;
    if (accept) begin
      exp_ch_d = (pcm_ch == LAST) ? 3'd0 : pcm_ch + 3'd1;
      if (pcm_ch != exp_ch_q && pcm_ch != 3'd0)
        seq_err_d = 1'b1;
    end
  end

  logic                     a_vld;
  logic signed [PROD_W-1:0] a_prod;
  logic [2:0]               a_shift;
  logic [1:0]               a_pan;
  logic [2:0]               a_ch;

  jt10_adpcma_atten u_atten (
    .clk      (clk),
    .rst_n    (rst_n),
    .clk_en_i (clk_en),
    .vld_i    (pcm_vld & ch_ok),
    .pcm_i    (pcm_in),
    .ch_i     (pcm_ch),
    .atten_i  (atten),
    .pan_i    (pan),
    .vld_o    (a_vld),
    .prod_o   (a_prod),
    .shift_o  (a_shift),
    .pan_o    (a_pan),
    .ch_o     (a_ch)
  );

  logic [3:0]              shamt;
  logic signed [ACC_W-1:0] scaled;
  logic signed [ACC_W-1:0] con_l, con_r;
  logic signed [ACC_W-1:0] sum_l, sum_r;
  logic signed [ACC_W-1:0] acc_l_q, acc_r_q;
  logic [PCM_W-1:0]        red_l, red_r;
  logic                    close;
  logic signed [OUT_W-1:0] out_l_q, out_r_q;
  logic                    stb_q;

  assign shamt  = 4'd7 + {1'b0, a_shift};
  assign scaled = ACC_W'(a_prod >>> shamt);
  assign con_l  = a_pan[1] ? scaled : '0;
  assign con_r  = a_pan[0] ? scaled : '0;

  // channel 0 restarts the frame
  assign sum_l = (a_ch == 3'd0) ? con_l : acc_l_q + con_l;
  assign sum_r = (a_ch == 3'd0) ? con_r : acc_r_q + con_r;
  assign close = a_vld & (a_ch == LAST);

`ifdef JT10_ADPCMA_SAT_EN
  assign red_l = sat12(sum_l);
  assign red_r = sat12(sum_r);
`else
  assign red_l = sum_l[PCM_W-1:0];
  assign red_r = sum_r[PCM_W-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_ch_q  <= '0;
      seq_err_q <= 1'b0;
      acc_l_q   <= '0;
      acc_r_q   <= '0;
      out_l_q   <= '0;
      out_r_q   <= '0;
      stb_q     <= 1'b0;
    end else begin
      exp_ch_q  <= exp_ch_d;
      seq_err_q <= seq_err_d;
      if (clk_en) begin
        stb_q <= close;
        if (a_vld) begin
          acc_l_q <= sum_l;
          acc_r_q <= sum_r;
        end
        if (close) begin
          out_l_q <= {{(OUT_W-PCM_W){red_l[PCM_W-1]}}, red_l};
          out_r_q <= {{(OUT_W-PCM_W){red_r[PCM_W-1]}}, red_r};
        end
      end
    end
  end

  assign adpcmA_l = out_l_q;
  assign adpcmA_r = out_r_q;
  assign out_stb  = stb_q;
  assign seq_err  = seq_err_q;

endmodule

// File: tb/tb_jt10_adpcma_mix.sv
// Directed bench for jt10_adpcma_mix: frame table plus
// sequences for back-to-back, gating, ordering and reset.
module tb_jt10_adpcma_mix;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               clk_en = 1'b0;
  logic               pcm_vld = 1'b0;
  logic signed [11:0] pcm_in = '0;
  logic [2:0]         pcm_ch = '0;
  logic [5:0]         atten = '0;
  logic [1:0]         pan = '0;
  logic signed [15:0] adpcmA_l, adpcmA_r;
  logic               out_stb, seq_err;

  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  jt10_adpcma_mix dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clk_en   (clk_en),
    .pcm_vld  (pcm_vld),
    .pcm_in   (pcm_in),
    .pcm_ch   (pcm_ch),
    .atten    (atten),
    .pan      (pan),
    .adpcmA_l (adpcmA_l),
    .adpcmA_r (adpcmA_r),
    .out_stb  (out_stb),
    .seq_err  (seq_err)
  );

  typedef struct {
    string            name;
    logic [5:0][11:0] pcm;
    logic [5:0][5:0]  att;
    logic [5:0][1:0]  pn;
    logic [15:0]      el;
    logic [15:0]      er;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [15:0] got,
                     input logic [15:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic vec_t mk(input string nm, input logic [11:0] p,
                              input logic [5:0] a, input logic [1:0] pn,
                              input logic [15:0] el, input logic [15:0] er);
    vec_t v;
    v.name = nm;
    for (int c = 0; c < 6; c++) begin
      v.pcm[c] = p;
      v.att[c] = a;
      v.pn[c]  = pn;
    end
    v.el = el;
    v.er = er;
    return v;
  endfunction

  task automatic push(input logic [2:0] ch, input logic [11:0] p,
                      input logic [5:0] a, input logic [1:0] pn);
    pcm_ch  = ch;
    pcm_in  = p;
    atten   = a;
    pan     = pn;
    pcm_vld = 1'b1;
    @(posedge clk); #1;
    pcm_vld = 1'b0;
  endtask

  task automatic run_frame(input vec_t v);
    for (int c = 0; c < 6; c++)
      push(3'(c), v.pcm[c], v.att[c], v.pn[c]);
    chk({v.name, " stb_early"}, 16'(out_stb), 16'd0);
    @(posedge clk); #1;
    chk({v.name, " stb"}, 16'(out_stb), 16'd1);
    chk({v.name, " left"}, adpcmA_l, v.el);
    chk({v.name, " right"}, adpcmA_r, v.er);
    @(posedge clk); #1;
    chk({v.name, " stb_drop"}, 16'(out_stb), 16'd0);
    chk({v.name, " left_hold"}, adpcmA_l, v.el);
  endtask

  initial begin
    vecs[0] = mk("unity", 12'd100, 6'd0, 2'd3, 16'd600, 16'd600);
    vecs[1] = mk("att9", 12'd0, 6'd9, 2'd2, 16'd457, 16'd0);
    vecs[1].pcm[0] = 12'd1000;
    vecs[2] = mk("att9_neg", 12'd0, 6'd9, 2'd2, 16'hFE36, 16'd0);
    vecs[2].pcm[0] = 12'hC18;
`ifdef JT10_ADPCMA_SAT_EN
    vecs[3] = mk("sat_pos", 12'd2047, 6'd0, 2'd3, 16'h07FF, 16'h07FF);
    vecs[5] = mk("sat_neg", 12'h800, 6'd0, 2'd3, 16'hF800, 16'hF800);
`else
    vecs[3] = mk("sat_pos", 12'd2047, 6'd0, 2'd3, 16'hFFFA, 16'hFFFA);
    vecs[5] = mk("sat_neg", 12'h800, 6'd0, 2'd3, 16'h0000, 16'h0000);
`endif
    vecs[4] = mk("pan_mix", 12'd200, 6'd8, 2'd0, 16'd400, 16'd300);
    vecs[4].pn[0] = 2'd3;
    vecs[4].pn[1] = 2'd2;
    vecs[4].pn[2] = 2'd1;
    vecs[4].pn[3] = 2'd0;
    vecs[4].pn[4] = 2'd3;
    vecs[4].pn[5] = 2'd2;
    vecs[6] = mk("att63", 12'd0, 6'd63, 2'd1, 16'd0, 16'd8);
    vecs[6].pcm[0] = 12'd2047;

    clk_en = 1'b1;
    #12;
    chk("reset left", adpcmA_l, 16'd0);
    chk("reset right", adpcmA_r, 16'd0);
    chk("reset stb", 16'(out_stb), 16'd0);
    chk("reset seq_err", 16'(seq_err), 16'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++)
      run_frame(vecs[i]);
    chk("table seq_err", 16'(seq_err), 16'd0);

    // back-to-back frames: 100s then 10s
    for (int k = 0; k < 12; k++) begin
      push(3'(k % 6), (k < 6) ? 12'd100 : 12'd10, 6'd0, 2'd3);
      if (k == 6) begin
        chk("b2b stb1", 16'(out_stb), 16'd1);
        chk("b2b left1", adpcmA_l, 16'd600);
      end
      if (k == 7)
        chk("b2b stb1_drop", 16'(out_stb), 16'd0);
    end
    @(posedge clk); #1;
    chk("b2b stb2", 16'(out_stb), 16'd1);
    chk("b2b right2", adpcmA_r, 16'd60);
    @(posedge clk); #1;

    // out-of-range channel ignored
    for (int c = 0; c < 3; c++) push(3'(c), 12'd100, 6'd0, 2'd3);
    push(3'd7, 12'd500, 6'd0, 2'd3);
    for (int c = 3; c < 6; c++) push(3'(c), 12'd100, 6'd0, 2'd3);
    @(posedge clk); #1;
    chk("inv stb", 16'(out_stb), 16'd1);
    chk("inv left", adpcmA_l, 16'd600);
    chk("inv seq_err", 16'(seq_err), 16'd0);
    @(posedge clk); #1;

    // clk_en gating inside the pipeline
    for (int c = 0; c < 6; c++) push(3'(c), 12'd50, 6'd0, 2'd3);
    clk_en = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("gate stb_held_low", 16'(out_stb), 16'd0);
    chk("gate left_old", adpcmA_l, 16'd600);
    clk_en = 1'b1;
    @(posedge clk); #1;
    chk("gate stb", 16'(out_stb), 16'd1);
    chk("gate left", adpcmA_l, 16'd300);
    chk("gate right", adpcmA_r, 16'd300);
    clk_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("gate stb_stretch", 16'(out_stb), 16'd1);
    clk_en = 1'b1;
    @(posedge clk); #1;
    chk("gate stb_drop", 16'(out_stb), 16'd0);

    // missing channel 2
    push(3'd0, 12'd100, 6'd0, 2'd3);
    push(3'd1, 12'd100, 6'd0, 2'd3);
    chk("seq before_gap", 16'(seq_err), 16'd0);
    push(3'd3, 12'd100, 6'd0, 2'd3);
    chk("seq after_ch3", 16'(seq_err), 16'd1);
    push(3'd4, 12'd100, 6'd0, 2'd3);
    push(3'd5, 12'd100, 6'd0, 2'd3);
    @(posedge clk); #1;
    chk("seq stb", 16'(out_stb), 16'd1);
    chk("seq left", adpcmA_l, 16'd500);
    @(posedge clk); #1;
    run_frame(mk("seq_clean", 12'd10, 6'd0, 2'd3, 16'd60, 16'd60));
    chk("seq sticky", 16'(seq_err), 16'd1);

    // async reset mid-frame
    for (int c = 0; c < 4; c++) push(3'(c), 12'd100, 6'd0, 2'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst left", adpcmA_l, 16'd0);
    chk("rst right", adpcmA_r, 16'd0);
    chk("rst stb", 16'(out_stb), 16'd0);
    chk("rst seq_err", 16'(seq_err), 16'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_frame(mk("post_rst", 12'd10, 6'd0, 2'd3, 16'd60, 16'd60));
    chk("post_rst seq_err", 16'(seq_err), 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
